// File: rtl/pimc_pkg.sv
// Shared definitions for the platform interrupt message controller:
// register field positions, reset values, FSM states and window layout.
package pimc_pkg;

  // Per-line table entry field positions
  localparam int PID_LSB  = 0;
  localparam int PID_MSB  = 7;
  localparam int MASK_BIT = 8;
  localparam int MODE_BIT = 9;
  localparam int PEND_BIT = 10;

  // Control/status register field positions
  localparam int CSR_EN_BIT   = 0;
  localparam int CSR_BUSY_BIT = 1;
  localparam int CSR_LAST_LSB = 8;
  localparam int CSR_LAST_MSB = 15;

  // Reset values of the programmable state
  localparam logic [7:0] PID_RST  = 8'h00;
  localparam logic       MASK_RST = 1'b1;
  localparam logic       MODE_RST = 1'b0;
  localparam logic       EN_RST   = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_NOTIFY = 1'b1
  } pimc_state_t;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } pimc_mode_t;

  // One programmable table entry
  typedef struct packed {
    logic [7:0] pid;
    logic       mask;
    pimc_mode_t mode;
  } pimc_entry_t;

  // Byte offset of the CSR from the window base: it sits right after the table
  function automatic logic [47:0] csr_offset(input int n);
    return 48'(4 * n);
  endfunction

endpackage

// File: rtl/pimc_rr_arbiter.sv
// Combinational round-robin arbiter: scans the request vector starting at
// 'start' and wrapping, granting the first asserted request.
module pimc_rr_arbiter #(
  parameter int N     = 16,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // First requester at or after 'start', wrapping through line 0
  always_comb begin
    int k;
    logic [IDX_W-1:0] k_idx;
    // NOTE: every output and temporary gets a default before any branch so no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    k     = 0;
    k_idx = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(start) + i;
      if (k >= N) k = k - N;
      k_idx = IDX_W'(k);
      if (!valid && req[k_idx]) begin
        valid = 1'b1;
        idx   = k_idx;
      end
    end
  end

endmodule

// File: rtl/pimc_gen2.sv
// Platform interrupt message controller, second generation: synchronises
// external interrupt lines, tracks per-line pending state through a writable
// mask/mode/target table, and presents one message at a time on a
// notify/ack handshake with round-robin fairness between lines.
module pimc_gen2
  import pimc_pkg::*;
#(
  parameter int          IRQ_PIN_COUNT = 16,
  parameter logic [47:0] MMIO_BASE     = 48'h1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IRQ_PIN_COUNT-1:0] irq_in,
  input  logic [47:0]              mmio_addr,
  input  logic                     mmio_re,
  input  logic                     mmio_we,
  input  logic [31:0]              mmio_wdata,
  output logic [31:0]              mmio_rdata,
  output logic                     notify,
  output logic [7:0]               lineno,
  output logic [7:0]               processor_id,
  input  logic                     irqack
);

  localparam int N     = IRQ_PIN_COUNT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Input synchroniser and edge history
  logic [N-1:0] sync1_q, sync_q, sync_prev_q;
  logic [N-1:0] rise;

  // Programmable state
  pimc_entry_t  table_q [N];
  logic         enable_q;

  // Pending state
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] mask_v, mode_v;
  logic [N-1:0] ack_clr;

  // Message state
  pimc_state_t      state_q, state_d;
  logic             grant_load, ack_fire;
  logic [7:0]       lineno_q, pid_q, last_q;
  logic [IDX_W-1:0] rr_start_q, cur_idx, nxt_idx;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  // MMIO decode
  logic [47:0]      off;
  logic [45:0]      word;
  logic             in_win, aligned, entry_hit, csr_hit;
  logic [IDX_W-1:0] sel_idx;
  logic [31:0]      rd_val, rdata_q;
  logic             unused_wdata;

  assign unused_wdata = ^mmio_wdata[31:MODE_BIT+1];

  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1_q     <= '0;
      sync_q      <= '0;
      sync_prev_q <= '0;
    end else begin
      sync1_q     <= irq_in;
      sync_q      <= sync1_q;
      sync_prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~sync_prev_q;

  // Address decode: entries first, CSR immediately after the last entry
  assign off       = mmio_addr - MMIO_BASE;
  assign word      = off[47:2];
  assign in_win    = (mmio_addr >= MMIO_BASE);
  assign aligned   = (off[1:0] == 2'b00);
  assign entry_hit = in_win && aligned && (word < 46'(N));
  assign csr_hit   = in_win && (off == csr_offset(N));
  assign sel_idx   = word[IDX_W-1:0];

  // Table and global enable writes
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is small and its reset values are architectural, so every entry is reset explicitly.
      for (int i = 0; i < N; i++) begin
        table_q[i].pid  <= PID_RST;
        table_q[i].mask <= MASK_RST;
        table_q[i].mode <= pimc_mode_t'(MODE_RST);
      end
      enable_q <= EN_RST;
    end else if (mmio_we) begin
      if (entry_hit) begin
        table_q[sel_idx].pid  <= mmio_wdata[PID_MSB:PID_LSB];
        table_q[sel_idx].mask <= mmio_wdata[MASK_BIT];
        table_q[sel_idx].mode <= pimc_mode_t'(mmio_wdata[MODE_BIT]);
      end
      if (csr_hit) enable_q <= mmio_wdata[CSR_EN_BIT];
    end
  end

  // Read mux for the addressed register
  always_comb begin
    rd_val = '0;
    if (entry_hit) begin
      rd_val[PID_MSB:PID_LSB] = table_q[sel_idx].pid;
      rd_val[MASK_BIT]        = table_q[sel_idx].mask;
      rd_val[MODE_BIT]        = table_q[sel_idx].mode;
      rd_val[PEND_BIT]        = pend_q[sel_idx];
    end else if (csr_hit) begin
      rd_val[CSR_EN_BIT]                = enable_q;
      rd_val[CSR_BUSY_BIT]              = notify;
      rd_val[CSR_LAST_MSB:CSR_LAST_LSB] = last_q;
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk) begin
    if (rst)          rdata_q <= '0;
    else if (mmio_re) rdata_q <= rd_val;
  end

  assign mmio_rdata = rdata_q;

  // Next pending state: level lines follow the input, edge lines latch rises
  always_comb begin
    mask_v  = '0;
    mode_v  = '0;
    ack_clr = '0;
    pend_d  = '0;
    for (int i = 0; i < N; i++) begin
      mask_v[i] = table_q[i].mask;
      mode_v[i] = (table_q[i].mode == MODE_EDGE);
    end
    if (ack_fire) ack_clr[cur_idx] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (mode_v[i]) pend_d[i] = ~mask_v[i] & (rise[i] | (pend_q[i] & ~ack_clr[i]));
      else           pend_d[i] = sync_q[i] & ~mask_v[i];
    end
  end

  // Pending register
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  pimc_rr_arbiter #(
    .N    (N),
    .IDX_W(IDX_W)
  ) u_arb (
    .req  (pend_q),
    .start(rr_start_q),
    .valid(grant_valid),
    .idx  (grant_idx)
  );

  assign cur_idx = lineno_q[IDX_W-1:0];
  assign nxt_idx = (int'(cur_idx) + 1 >= N) ? '0 : cur_idx + 1'b1;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: grant from IDLE, retire the message on acknowledge
  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    ack_fire   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_q && grant_valid) begin
          state_d    = ST_NOTIFY;
          grant_load = 1'b1;
        end
      end
      ST_NOTIFY: begin
        if (irqack) begin
          state_d  = ST_IDLE;
          ack_fire = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Message latch, last-serviced record and round-robin start pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      lineno_q   <= '0;
      pid_q      <= '0;
      last_q     <= '0;
      rr_start_q <= '0;
    end else begin
      if (grant_load) begin
        lineno_q <= 8'(grant_idx);
        pid_q    <= table_q[grant_idx].pid;
      end
      if (ack_fire) begin
        last_q     <= lineno_q;
        rr_start_q <= nxt_idx;
      end
    end
  end

  assign notify       = (state_q == ST_NOTIFY);
  assign lineno       = lineno_q;
  assign processor_id = pid_q;

endmodule
